mtp_thread_sched: RTL
=====================

# mtp_thread_sched

Multi-threaded successor to the single-threaded pipeline front end. It holds `NUM_THREADS` independent thread contexts, each with a PC and a state machine. Every cycle it selects one ready thread round-robin and issues its fetch request to the shared `ifetch_unit`. It also retires threads on halt and reports completion to the thread manager. It sits between the thread manager and `ifetch_unit` in the multi-threaded pipeline top.

## Interface
Parameters:
- `NUM_THREADS`, 4: number of hardware thread contexts (≥2).
- `PC_WIDTH`, 32: program counter width.
- `FETCH_BYTES`, 8: PC increment per fetch (one `opcode0`/`opcode1` pair).
- `TID_WIDTH`, `$clog2(NUM_THREADS)`: thread-id width.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `tm_start_vld`, input, 1: thread manager requests a thread start.
- `tm_start_tid`, input, `TID_WIDTH`: thread to start.
- `tm_start_pc`, input, `PC_WIDTH`: start PC.
- `tm_start_ready`, output, 1: combinational; high when thread `tm_start_tid` is IDLE and reset is low.
- `tm_done_vld`, output, 1: one-cycle pulse when a thread halts.
- `tm_done_tid`, output, `TID_WIDTH`: id of the halted thread.
- `fetch_req_vld`, output, 1: registered fetch request.
- `fetch_req_tid`, output, `TID_WIDTH`: requesting thread.
- `fetch_req_pc`, output, `PC_WIDTH`: fetch address.
- `fetch_req_ready`, input, 1: `ifetch_unit` accepts the request.
- `fetch_rsp_vld`, input, 1: fetch/decode result returned.
- `fetch_rsp_tid`, input, `TID_WIDTH`: thread of the result.
- `fetch_rsp_halt`, input, 1: fetched pair contains a halt.
- `fetch_rsp_br_vld`, input, 1: redirect taken.
- `fetch_rsp_br_pc`, input, `PC_WIDTH`: redirect target.
- `wb_stall`, input, 1: writeback/lane backpressure; blocks new issue.
- `thread_active`, output, `NUM_THREADS`: bit *i* is high when thread *i* is not IDLE.
- `rsp_err`, output, 1: sticky; set when a response arrives for a thread not in WAIT.

## Operation
- Per-thread states: IDLE, READY, WAIT.
  - IDLE→READY when the start handshake completes (`tm_start_vld && tm_start_ready`). PC is loaded with `tm_start_pc`.
  - READY→WAIT when this thread's request is accepted (`fetch_req_vld && fetch_req_ready`).
  - WAIT→IDLE when `fetch_rsp_vld` arrives for this thread with `fetch_rsp_halt=1`. `tm_done_vld` pulses the next cycle with that tid.
  - WAIT→READY when `fetch_rsp_vld` arrives for this thread with `fetch_rsp_halt=0`.
    - PC becomes `fetch_rsp_br_pc` if `fetch_rsp_br_vld=1`.
    - Otherwise PC becomes PC+`FETCH_BYTES`, modulo 2^`PC_WIDTH` (wraps silently).
- Arbitration:
  - A round-robin pointer `rr` marks the highest-priority thread. Search order is `rr`, `rr`+1, … modulo `NUM_THREADS`.
  - On each accepted request, `rr` becomes granted tid+1 (wrapping).
- Request register:
  - When `fetch_req_vld=0`, or a handshake completes this cycle, and `wb_stall=0`, the scheduler loads the next READY winner. A thread going READY→WAIT this cycle is excluded.
  - If no thread is READY, `fetch_req_vld` becomes 0.
  - While `fetch_req_vld=1` and `fetch_req_ready=0`, the request holds `tid`/`pc` stable, even if `wb_stall` rises.
- `rsp_err`: a response for a non-WAIT thread is ignored and sets `rsp_err`. Only reset clears it.
- Simultaneous events:
  - A start and a response never target the same thread legally, because start requires IDLE and a response requires WAIT.
  - A halt completion and a new start of that same tid in the same cycle: the start is not accepted, because `tm_start_ready` still sees WAIT.

## Timing
- Reset values: all threads IDLE, all PCs 0, `rr`=0, `fetch_req_vld`=0, `fetch_req_tid`=0, `fetch_req_pc`=0, `tm_done_vld`=0, `tm_done_tid`=0, `thread_active`=0, `rsp_err`=0.
- Start accepted at edge N → thread READY and `thread_active` bit set after N. The earliest `fetch_req_vld` for it is after edge N+1.
- Request accepted at edge M → the next request (another READY thread) can be valid after edge M, giving back-to-back issue.
- Response with halt at edge K → `tm_done_vld` is high for exactly the cycle after K. `thread_active` bit clears after K.
- Response without halt at edge K → the thread is eligible at the reload at edge K+1.
- Reset asserted mid-operation: everything returns to reset values at that edge. Outstanding responses received afterwards set `rsp_err`.

## Configuration
- `MTP_PERF_CNT_EN` defined:
  - Adds output `perf_fetch_cnt [NUM_THREADS-1:0]`, 32 bits each.
  - Counter *i* increments on each accepted request for thread *i*, saturates at 2^32−1, and resets to 0.
- `MTP_PERF_CNT_EN` undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Single thread: start tid 1 at PC 0x100, `fetch_req_ready`=1, three non-halt responses → requests at 0x100, 0x108, 0x110; a halt response then gives a `tm_done_vld` pulse with tid 1 and `thread_active`=0.
- Four threads started at PC 0x0/0x1000/0x2000/0x3000, `ready` always 1, responses returned 2 cycles after each request → grant order 0,1,2,3,0… with no thread granted twice in a row.
- Hold `fetch_req_ready`=0 for 5 cycles while `wb_stall` toggles → `fetch_req_tid`/`fetch_req_pc` stay stable; with stall high after acceptance, `fetch_req_vld`=0.
- Branch response for tid 2 with `br_pc`=0x4000 → next tid-2 request is at 0x4000. Thread at PC 0xFFFFFFF8 with a non-branch response → next request at 0x0.
- Response for an IDLE tid → `rsp_err`=1 and no state change; reset mid-run with 3 threads active → all outputs return to reset values the next cycle.
- With `MTP_PERF_CNT_EN`: 10 accepted requests for tid 0 → `perf_fetch_cnt[0]`=10; counter preloaded near max stops at 0xFFFFFFFF.

Source files
------------

// File: rtl/mtp_thread_sched.sv
// Round-robin fetch scheduler for NUM_THREADS hardware thread contexts (IDLE/READY/WAIT each).
// Define MTP_PERF_CNT_EN to add per-thread saturating accepted-fetch counters on perf_fetch_cnt.
module mtp_thread_sched #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32,
    parameter int FETCH_BYTES = 8,
    parameter int TID_WIDTH   = $clog2(NUM_THREADS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tm_start_vld,
    input  logic [TID_WIDTH-1:0]            tm_start_tid,
    input  logic [PC_WIDTH-1:0]             tm_start_pc,
    output logic                            tm_start_ready,
    output logic                            tm_done_vld,
    output logic [TID_WIDTH-1:0]            tm_done_tid,
    output logic                            fetch_req_vld,
    output logic [TID_WIDTH-1:0]            fetch_req_tid,
    output logic [PC_WIDTH-1:0]             fetch_req_pc,
    input  logic                            fetch_req_ready,
    input  logic                            fetch_rsp_vld,
    input  logic [TID_WIDTH-1:0]            fetch_rsp_tid,
    input  logic                            fetch_rsp_halt,
    input  logic                            fetch_rsp_br_vld,
    input  logic [PC_WIDTH-1:0]             fetch_rsp_br_pc,
    input  logic                            wb_stall,
    output logic [NUM_THREADS-1:0]          thread_active,
    output logic                            rsp_err
`ifdef MTP_PERF_CNT_EN
    ,
    output logic [NUM_THREADS*32-1:0]       perf_fetch_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    function automatic logic [TID_WIDTH-1:0] wrap_add(input logic [TID_WIDTH-1:0] a,
                                                      input int unsigned b);
        int unsigned s;
        s = {{(32-TID_WIDTH){1'b0}}, a} + b;
        if (s >= unsigned'(NUM_THREADS)) begin
            s = s - unsigned'(NUM_THREADS);
        end
        return TID_WIDTH'(s);
    endfunction

    logic [1:0]             st_arr [NUM_THREADS];
    logic [PC_WIDTH-1:0]    pc_arr [NUM_THREADS];
    logic [NUM_THREADS-1:0] elig;

    logic                   accept;
    logic                   start_fire;
    logic                   rsp_in_wait;

    logic                   req_vld_q, req_vld_d;
    logic [TID_WIDTH-1:0]   req_tid_q, req_tid_d;
    logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic [TID_WIDTH-1:0]   rr_q, rr_d;
    logic                   done_vld_q, done_vld_d;
    logic [TID_WIDTH-1:0]   done_tid_q, done_tid_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   found;
    logic [TID_WIDTH-1:0]   win;
    logic [TID_WIDTH-1:0]   base;
    logic [TID_WIDTH-1:0]   idx;

    assign accept         = req_vld_q && fetch_req_ready;
    assign tm_start_ready = !reset && (st_arr[tm_start_tid] == ST_IDLE);
    assign start_fire     = tm_start_vld && tm_start_ready;
    assign rsp_in_wait    = (st_arr[fetch_rsp_tid] == ST_WAIT);

    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
            logic [1:0]          st_q, st_d;
            logic [PC_WIDTH-1:0] pc_q, pc_d;
            logic                start_hit, grant_hit, rsp_hit;

            assign start_hit = start_fire && (tm_start_tid == TID_WIDTH'(gi));
            assign grant_hit = accept && (req_tid_q == TID_WIDTH'(gi));
            assign rsp_hit   = fetch_rsp_vld && (fetch_rsp_tid == TID_WIDTH'(gi));

            always_comb begin
                st_d = st_q;
                pc_d = pc_q;
                case (st_q)
                    ST_IDLE: begin
                        if (start_hit) begin
                            st_d = ST_READY;
                            pc_d = tm_start_pc;
                        end
                    end
                    ST_READY: begin
                        if (grant_hit) begin
                            st_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (rsp_hit) begin
                            if (fetch_rsp_halt) begin
                                st_d = ST_IDLE;
                            end else begin
                                st_d = ST_READY;
                                pc_d = fetch_rsp_br_vld ? fetch_rsp_br_pc
                                                        : pc_q + PC_WIDTH'(FETCH_BYTES);
                            end
                        end
                    end
                    default: st_d = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    st_q <= ST_IDLE;
                    pc_q <= '0;
                end else begin
                    st_q <= st_d;
                    pc_q <= pc_d;
                end
            end

            assign st_arr[gi]        = st_q;
            assign pc_arr[gi]        = pc_q;
            assign thread_active[gi] = (st_q != ST_IDLE);
            // The thread being granted this cycle must not be picked again for the reload.
            assign elig[gi]          = (st_q == ST_READY) && !grant_hit;

`ifdef MTP_PERF_CNT_EN
            logic [31:0] cnt_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (grant_hit && (cnt_q != 32'hFFFF_FFFF)) begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end
            assign perf_fetch_cnt[gi*32 +: 32] = cnt_q;
`endif
        end
    endgenerate

    // On an accept the search already starts after the granted thread, so issue stays fair back-to-back.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        base  = accept ? wrap_add(req_tid_q, 1) : rr_q;
        for (int k = 0; k < NUM_THREADS; k++) begin
            idx = wrap_add(base, unsigned'(k));
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_vld_d = req_vld_q;
        req_tid_d = req_tid_q;
        req_pc_d  = req_pc_q;
        if ((!req_vld_q || accept) && !wb_stall) begin
            req_vld_d = found;
            if (found) begin
                req_tid_d = win;
                req_pc_d  = pc_arr[win];
            end
        end else if (accept) begin
            req_vld_d = 1'b0;
        end
        rr_d       = accept ? wrap_add(req_tid_q, 1) : rr_q;
        done_vld_d = fetch_rsp_vld && rsp_in_wait && fetch_rsp_halt;
        done_tid_d = done_vld_d ? fetch_rsp_tid : done_tid_q;
        rsp_err_d  = rsp_err_q || (fetch_rsp_vld && !rsp_in_wait);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_vld_q  <= 1'b0;
            req_tid_q  <= '0;
            req_pc_q   <= '0;
            rr_q       <= '0;
            done_vld_q <= 1'b0;
            done_tid_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            req_vld_q  <= req_vld_d;
            req_tid_q  <= req_tid_d;
            req_pc_q   <= req_pc_d;
            rr_q       <= rr_d;
            done_vld_q <= done_vld_d;
            done_tid_q <= done_tid_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign fetch_req_vld = req_vld_q;
    assign fetch_req_tid = req_tid_q;
    assign fetch_req_pc  = req_pc_q;
    assign tm_done_vld   = done_vld_q;
    assign tm_done_tid   = done_tid_q;
    assign rsp_err       = rsp_err_q;

endmodule
